dma_dev_bridge: RTL and testbench

- Device-side front end of the DMA controller; sits directly upstream of it and drives its device interface (rqst, num_words, start_addr, rd_wr, dev_ack, dev_in), consuming dma_ack, dev_out, end_flag and error_flag.
- Converts a peripheral's command plus valid/ready data streams into the controller's request/ack protocol.
- Contains one small elastic buffer so the peripheral never has to react combinationally to dma_ack.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_elastic_buf.sv | 74 +++++++
 rtl/dma_dev_bridge.sv | 258 +++++++++++++++++++++++++
 tb/tb_dma_dev_bridge.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA device-side bridge: FSM state encoding,
// transfer direction codes and default bus widths.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_XFER  = 2'd2,
    ST_DRAIN = 2'd3
  } dma_state_e;

  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

  localparam int ADD_LEN_DEF  = 16;
  localparam int DATA_LEN_DEF = 16;

endpackage

// File: rtl/dma_elastic_buf.sv
// Small synchronous FIFO with occupancy count and flush. A push into a full
// buffer is accepted only when a pop frees the head in the same cycle.
module dma_elastic_buf
  import dma_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rdata,
  output logic [BUF_DEPTH:0]  count,
  output logic                full,
  output logic                empty
);

  localparam int ENTRIES = 1 << BUF_DEPTH;
  localparam int CNT_W   = BUF_DEPTH + 1;

  logic [DATA_LEN-1:0]  mem_q [ENTRIES];
  logic [BUF_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok, pop_ok;

  assign empty   = (count_q == CNT_W'(0));
  assign full    = (count_q == CNT_W'(ENTRIES));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = BUF_DEPTH'(0);
      rd_ptr_d = BUF_DEPTH'(0);
      count_d  = CNT_W'(0);
    end else begin
      // pointers wrap naturally modulo the entry count
      if (push_ok) wr_ptr_d = wr_ptr_q + BUF_DEPTH'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + BUF_DEPTH'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= BUF_DEPTH'(0);
      rd_ptr_q <= BUF_DEPTH'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dma_dev_bridge.sv
// Device-side front end of the DMA controller: turns a command plus valid/ready
// streams into rqst/dev_ack signalling. Define DMA_DEV_TIMEOUT_EN for a watchdog abort.
module dma_dev_bridge
  import dma_pkg::*;
#(
  parameter int ADD_LEN     = ADD_LEN_DEF,
  parameter int DATA_LEN    = DATA_LEN_DEF,
  parameter int BUF_DEPTH   = 2,
  parameter int TIMEOUT_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADD_LEN-1:0]  cmd_words,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic                cmd_rd,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_LEN-1:0] src_data,
  output logic                snk_valid,
  input  logic                snk_ready,
  output logic [DATA_LEN-1:0] snk_data,
  output logic                rqst,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                rd_wr,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag,
  input  logic                error_flag,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADD_LEN-1:0]  words_done
);

  localparam int ENTRIES = 1 << BUF_DEPTH;
  localparam int CNT_W   = BUF_DEPTH + 1;

  dma_state_e          state_q, state_d;
  logic [ADD_LEN-1:0]  num_words_q, num_words_d, words_done_q, words_done_d;
  logic [ADD_LEN-1:0]  acc_cnt_q, acc_cnt_d;
  logic [ADD_LEN:0]    start_addr_q, start_addr_d;
  logic                rd_wr_q, rd_wr_d, fault_q, fault_d;
  logic                cmd_ready_q, cmd_ready_d, rqst_q, rqst_d, busy_q, busy_d;
  logic                done_q, done_d, err_q, err_d;
  logic                go_idle_s, fail_s, in_xfer_s, wr_active_s, ack_s;
  logic                src_hs_s, snk_hs_s, underflow_s, overflow_s;
  logic                buf_push_s, buf_pop_s, buf_flush_s, buf_full_s, buf_empty_s;
  logic [CNT_W-1:0]    buf_count_s;
  logic [ADD_LEN-1:0]  remaining_s;
  logic [DATA_LEN-1:0] buf_wdata_s, buf_rdata_s;

`ifdef DMA_DEV_TIMEOUT_EN
  logic [TIMEOUT_LEN-1:0] wdog_q, wdog_d;
`else
  logic [TIMEOUT_LEN-1:0] unused_timeout_s;
  assign unused_timeout_s = {TIMEOUT_LEN{1'b0}};
`endif

  assign in_xfer_s   = (state_q == ST_XFER);
  assign wr_active_s = (rd_wr_q == DIR_WR) && ((state_q == ST_REQ) || in_xfer_s);
  assign ack_s       = in_xfer_s && dma_ack;
  assign remaining_s = num_words_q - words_done_q;
  assign src_ready   = wr_active_s && !buf_full_s && (acc_cnt_q < num_words_q);
  assign src_hs_s    = src_valid && src_ready;
  assign snk_valid   = (rd_wr_q == DIR_RD) && !buf_empty_s;
  assign snk_hs_s    = snk_valid && snk_ready;
  assign snk_data    = buf_rdata_s;
  assign dev_in      = buf_rdata_s;
  assign underflow_s = ack_s && (rd_wr_q == DIR_WR) && buf_empty_s;
  assign overflow_s  = ack_s && (rd_wr_q == DIR_RD) && buf_full_s && !snk_hs_s;

  always_comb begin
    if (rd_wr_q == DIR_RD) begin
      buf_push_s  = ack_s;
      buf_pop_s   = snk_hs_s;
      buf_wdata_s = dev_out;
    end else begin
      buf_push_s  = src_hs_s;
      buf_pop_s   = ack_s;
      buf_wdata_s = src_data;
    end
  end

  // write side offers data once two words are queued or the tail of the transfer is fully queued
  always_comb begin
    if (!in_xfer_s) begin
      dev_ack = 1'b0;
    end else if (rd_wr_q == DIR_RD) begin
      dev_ack = (buf_count_s <= CNT_W'(ENTRIES - 2));
    end else begin
      dev_ack = (buf_count_s >= CNT_W'(2)) ||
                (!buf_empty_s && (ADD_LEN'(buf_count_s) >= remaining_s));
    end
  end

  always_comb begin
    state_d      = state_q;
    num_words_d  = num_words_q;
    start_addr_d = start_addr_q;
    rd_wr_d      = rd_wr_q;
    fault_d      = fault_q || underflow_s || overflow_s;
    go_idle_s    = 1'b0;
    fail_s       = 1'b0;
    buf_flush_s  = 1'b0;
    if (src_hs_s) acc_cnt_d = acc_cnt_q + ADD_LEN'(1);
    else          acc_cnt_d = acc_cnt_q;
    if (ack_s)    words_done_d = words_done_q + ADD_LEN'(1);
    else          words_done_d = words_done_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          num_words_d  = cmd_words;
          start_addr_d = cmd_addr;
          rd_wr_d      = cmd_rd;
          words_done_d = {ADD_LEN{1'b0}};
          acc_cnt_d    = {ADD_LEN{1'b0}};
          fault_d      = 1'b0;
          buf_flush_s  = 1'b1;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: state_d = ST_XFER;
      ST_XFER: begin
        if (error_flag) begin
          fault_d = 1'b1;
          if (rd_wr_q == DIR_RD) begin
            state_d = ST_DRAIN;
          end else begin
            go_idle_s = 1'b1;
            fail_s    = 1'b1;
          end
        end else if (end_flag) begin
          if (rd_wr_q == DIR_RD) begin
            state_d = ST_DRAIN;
          end else begin
            go_idle_s = 1'b1;
            fail_s    = fault_q || underflow_s;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (buf_empty_s) begin
          go_idle_s = 1'b1;
          fail_s    = fault_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        go_idle_s = 1'b1;
        fail_s    = 1'b1;
      end
    endcase
`ifdef DMA_DEV_TIMEOUT_EN
    wdog_d = {TIMEOUT_LEN{1'b0}};
    if ((state_q == ST_REQ) || in_xfer_s) begin
      if (wdog_q == {TIMEOUT_LEN{1'b1}}) begin
        go_idle_s = 1'b1;
        fail_s    = 1'b1;
      end else if (ack_s) begin
        wdog_d = {TIMEOUT_LEN{1'b0}};
      end else begin
        wdog_d = wdog_q + TIMEOUT_LEN'(1);
      end
    end else begin
      wdog_d = {TIMEOUT_LEN{1'b0}};
    end
`endif
    // leaving a transfer clears the request fields and discards any leftover words
    if (go_idle_s) begin
      state_d      = ST_IDLE;
      num_words_d  = {ADD_LEN{1'b0}};
      start_addr_d = {(ADD_LEN + 1){1'b0}};
      rd_wr_d      = DIR_WR;
      buf_flush_s  = 1'b1;
    end else begin
      buf_flush_s  = buf_flush_s;
    end
    cmd_ready_d = (state_d == ST_IDLE);
    rqst_d      = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
    done_d      = go_idle_s && !fail_s;
    err_d       = go_idle_s && fail_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      num_words_q  <= {ADD_LEN{1'b0}};
      start_addr_q <= {(ADD_LEN + 1){1'b0}};
      rd_wr_q      <= DIR_WR;
      words_done_q <= {ADD_LEN{1'b0}};
      acc_cnt_q    <= {ADD_LEN{1'b0}};
      fault_q      <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rqst_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      start_addr_q <= start_addr_d;
      rd_wr_q      <= rd_wr_d;
      words_done_q <= words_done_d;
      acc_cnt_q    <= acc_cnt_d;
      fault_q      <= fault_d;
      cmd_ready_q  <= cmd_ready_d;
      rqst_q       <= rqst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef DMA_DEV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) wdog_q <= {TIMEOUT_LEN{1'b0}};
    else       wdog_q <= wdog_d;
  end
`endif

  assign cmd_ready  = cmd_ready_q;
  assign rqst       = rqst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign num_words  = num_words_q;
  assign start_addr = start_addr_q;
  assign rd_wr      = rd_wr_q;
  assign words_done = words_done_q;

  dma_elastic_buf #(
    .DATA_LEN  (DATA_LEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (buf_flush_s),
    .push  (buf_push_s),
    .pop   (buf_pop_s),
    .wdata (buf_wdata_s),
    .rdata (buf_rdata_s),
    .count (buf_count_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

endmodule

// File: tb/tb_dma_dev_bridge.sv
// Directed self-checking bench for dma_dev_bridge; the DMA side and the
// peripheral streams are driven from per-scenario tasks.
module tb_dma_dev_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_rd;
  logic [15:0] cmd_words;
  logic [16:0] cmd_addr;
  logic        src_valid, src_ready, snk_valid, snk_ready;
  logic [15:0] src_data, snk_data;
  logic        rqst, rd_wr, dev_ack, dma_ack, end_flag, error_flag;
  logic [15:0] num_words, dev_in, dev_out, words_done;
  logic [16:0] start_addr;
  logic        busy, done, err;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_dev_bridge #(.ADD_LEN(16), .DATA_LEN(16), .BUF_DEPTH(2), .TIMEOUT_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_words(cmd_words),
    .cmd_addr(cmd_addr), .cmd_rd(cmd_rd),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .rqst(rqst), .num_words(num_words), .start_addr(start_addr), .rd_wr(rd_wr),
    .dev_ack(dev_ack), .dev_in(dev_in),
    .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag), .error_flag(error_flag),
    .busy(busy), .done(done), .err(err), .words_done(words_done)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_ready, busy, rqst, dev_ack, src_ready, snk_valid, done, err, rd_wr} !== 9'b100000000) begin
      $display("FAIL reset_flags got=%b want=100000000",
               {cmd_ready, busy, rqst, dev_ack, src_ready, snk_valid, done, err, rd_wr});
      bad++;
    end
    total++;
    if ({words_done, num_words, start_addr} !== 49'd0) begin
      $display("FAIL reset_fields wd=%h nw=%h sa=%h want 0", words_done, num_words, start_addr);
      bad++;
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL idle_after_reset cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
      bad++;
    end
  endtask

  // write transfer; err_at < 0 ends with end_flag after n acks, otherwise error_flag after err_at acks
  task automatic test_write(input int n, input int err_at, input logic [16:0] addr, input logic [15:0] base);
    int acks, acc, rq;
    bit fin, term, hs;
    logic exp_done;
    logic [15:0] exp_wd;
    exp_done = (err_at < 0);
    exp_wd = (err_at < 0) ? 16'(n) : 16'(err_at);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_words = 16'(n); cmd_addr = addr; cmd_rd = 1'b0;
    src_valid = 1'b1; src_data = base;
    @(negedge clk);
    cmd_valid = 1'b0;
    acks = 0; acc = 0; rq = 0; fin = 1'b0; term = 1'b0; hs = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (hs) begin acc++; src_data = base + 16'(acc); end
      hs = src_valid && src_ready;
      dma_ack = 1'b0; end_flag = 1'b0; error_flag = 1'b0;
      if (rqst) rq++;
      if (done || err) begin
        fin = 1'b1;
        total++;
        if (done !== exp_done || err !== !exp_done || term !== 1'b1) begin
          $display("FAIL wr_pulse done=%b err=%b term=%b want done=%b", done, err, term, exp_done);
          bad++;
        end
        total++;
        if (words_done !== exp_wd) begin
          $display("FAIL wr_words_done got=%0d want=%0d", words_done, exp_wd);
          bad++;
        end
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || num_words !== 16'd0 || start_addr !== 17'd0 ||
            dev_ack !== 1'b0 || src_ready !== 1'b0) begin
          $display("FAIL wr_idle cmd_ready=%b busy=%b nw=%h sa=%h dev_ack=%b src_ready=%b",
                   cmd_ready, busy, num_words, start_addr, dev_ack, src_ready);
          bad++;
        end
        total++;
        if (rq !== 1 || (exp_done && acc !== n)) begin
          $display("FAIL wr_counts rqst_pulses=%0d want 1, accepted=%0d want %0d", rq, acc, n);
          bad++;
        end
      end else begin
        if (busy) begin
          total++;
          if (num_words !== 16'(n) || start_addr !== addr || rd_wr !== 1'b0) begin
            $display("FAIL wr_req_hold nw=%h sa=%h rd_wr=%b want %h %h 0", num_words, start_addr, rd_wr, n, addr);
            bad++;
          end
        end
        if (rq > 0 && !rqst && !term && ((err_at >= 0 && acks == err_at) || (err_at < 0 && acks == n))) begin
          if (err_at >= 0) error_flag = 1'b1;
          else             end_flag = 1'b1;
          term = 1'b1;
        end else if (!term && dev_ack && acks < n) begin
          total++;
          if (dev_in !== base + 16'(acks)) begin
            $display("FAIL wr_dev_in word=%0d got=%h want=%h", acks, dev_in, base + 16'(acks));
            bad++;
          end
          dma_ack = 1'b1;
          acks++;
        end
      end
      @(negedge clk);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL wr_timeout no done/err pulse, acks=%0d", acks);
    end
    src_valid = 1'b0; dma_ack = 1'b0; end_flag = 1'b0; error_flag = 1'b0;
    total++;
    if (done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL wr_pulse_width done=%b err=%b want 0/0", done, err);
      bad++;
    end
  endtask

  task automatic test_read8();
    logic [15:0] rd_data [8];
    int sent, rcv, occ, rq;
    bit xf, term, fin, push, pop;
    for (int i = 0; i < 8; i++) rd_data[i] = 16'hA000 + 16'(i * 16'h0111);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_words = 16'd8; cmd_addr = 17'h00400; cmd_rd = 1'b1; snk_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    sent = 0; rcv = 0; occ = 0; rq = 0; xf = 1'b0; term = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      snk_ready = (cyc % 2 == 1);
      dma_ack = 1'b0; end_flag = 1'b0; push = 1'b0; pop = 1'b0;
      if (rqst) rq++;
      if (done || err) begin
        fin = 1'b1;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || rcv !== 8 || words_done !== 16'd8 || rq !== 1) begin
          $display("FAIL rd_done done=%b err=%b rcv=%0d wd=%0d rqst_pulses=%0d want 1 0 8 8 1",
                   done, err, rcv, words_done, rq);
          bad++;
        end
      end else begin
        total++;
        if (dev_ack !== (xf && occ <= 2)) begin
          $display("FAIL rd_dev_ack cyc=%0d got=%b want=%b", cyc, dev_ack, (xf && occ <= 2));
          bad++;
        end
        total++;
        if (snk_valid !== (occ != 0) || (busy && (num_words !== 16'd8 || start_addr !== 17'h00400 || rd_wr !== 1'b1))) begin
          $display("FAIL rd_state cyc=%0d snk_valid=%b want=%b nw=%h sa=%h rd_wr=%b",
                   cyc, snk_valid, (occ != 0), num_words, start_addr, rd_wr);
          bad++;
        end
        if (snk_valid && snk_ready) begin
          total++;
          if (rcv > 7 || snk_data !== rd_data[rcv & 7]) begin
            $display("FAIL rd_snk_data idx=%0d got=%h want=%h", rcv, snk_data, rd_data[rcv & 7]);
            bad++;
          end
          rcv++;
          pop = 1'b1;
        end
        if (xf && sent == 8 && !term) begin
          end_flag = 1'b1;
          term = 1'b1;
        end else if (dev_ack && sent < 8) begin
          dma_ack = 1'b1;
          dev_out = rd_data[sent];
          sent++;
          push = 1'b1;
        end
        occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
        if (rqst) xf = 1'b1;
        if (end_flag) xf = 1'b0;
      end
      @(negedge clk);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL rd_timeout sent=%0d rcv=%0d", sent, rcv);
    end
    dma_ack = 1'b0; end_flag = 1'b0; snk_ready = 1'b0;
  endtask

  task automatic test_zero_words();
    int rq;
    bit fin, term;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_words = 16'd0; cmd_addr = 17'h00010; cmd_rd = 1'b0;
    src_valid = 1'b1; src_data = 16'hBEEF; snk_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rq = 0; fin = 1'b0; term = 1'b0;
    for (int cyc = 0; cyc < 50 && !fin; cyc++) begin
      end_flag = 1'b0;
      if (rqst) rq++;
      total++;
      if (src_ready !== 1'b0 || snk_valid !== 1'b0 || dev_ack !== 1'b0) begin
        $display("FAIL zero_activity src_ready=%b snk_valid=%b dev_ack=%b want 0", src_ready, snk_valid, dev_ack);
        bad++;
      end
      if (done || err) begin
        fin = 1'b1;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || words_done !== 16'd0 || rq !== 1) begin
          $display("FAIL zero_done done=%b err=%b wd=%0d rqst_pulses=%0d want 1 0 0 1", done, err, words_done, rq);
          bad++;
        end
      end else if (rq > 0 && !rqst && !term) begin
        end_flag = 1'b1;
        term = 1'b1;
      end
      @(negedge clk);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL zero_timeout no pulse");
    end
    src_valid = 1'b0; end_flag = 1'b0; snk_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int sent;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_words = 16'd8; cmd_addr = 17'h00800; cmd_rd = 1'b1; snk_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 50 && sent < 2; cyc++) begin
      dma_ack = 1'b0;
      if (dev_ack) begin dma_ack = 1'b1; dev_out = 16'h7700 + 16'(sent); sent++; end
      @(negedge clk);
    end
    dma_ack = 1'b0;
    total++;
    if (sent !== 2 || busy !== 1'b1 || snk_valid !== 1'b1) begin
      $display("FAIL rst_mid_setup sent=%0d busy=%b snk_valid=%b want 2 1 1", sent, busy, snk_valid);
      bad++;
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({cmd_ready, busy, rqst, dev_ack, src_ready, snk_valid, done, err, rd_wr} !== 9'b100000000 ||
        {words_done, num_words, start_addr} !== 49'd0) begin
      $display("FAIL rst_mid_outputs flags=%b wd=%h nw=%h sa=%h",
               {cmd_ready, busy, rqst, dev_ack, src_ready, snk_valid, done, err, rd_wr},
               words_done, num_words, start_addr);
      bad++;
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1 || snk_valid !== 1'b0) begin
      $display("FAIL rst_mid_after done=%b err=%b cmd_ready=%b snk_valid=%b want 0 0 1 0",
               done, err, cmd_ready, snk_valid);
      bad++;
    end
  endtask

  task automatic test_no_ack();
    int err_cyc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_words = 16'd2; cmd_addr = 17'h00020; cmd_rd = 1'b0; src_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    err_cyc = -1;
`ifdef DMA_DEV_TIMEOUT_EN
    for (int cyc = 0; cyc < 40 && err_cyc < 0; cyc++) begin
      if (err) err_cyc = cyc;
      else @(negedge clk);
    end
    total++;
    if (err_cyc < 14 || err_cyc > 18 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      $display("FAIL timeout_abort err_cycle=%0d want 14..18, done=%b cmd_ready=%b", err_cyc, done, cmd_ready);
      bad++;
    end
    @(negedge clk);
`else
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (err || done || !busy) err_cyc = cyc;
      @(negedge clk);
    end
    total++;
    if (err_cyc !== -1 || busy !== 1'b1 || rqst !== 1'b0) begin
      $display("FAIL no_ack_wait left busy at cycle=%0d busy=%b rqst=%b want stay busy", err_cyc, busy, rqst);
      bad++;
    end
    end_flag = 1'b1;
    @(negedge clk);
    end_flag = 1'b0;
    total++;
    if (done !== 1'b1 || err !== 1'b0 || words_done !== 16'd0) begin
      $display("FAIL no_ack_end done=%b err=%b wd=%0d want 1 0 0", done, err, words_done);
      bad++;
    end
`endif
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_words = 16'd0; cmd_addr = 17'd0; cmd_rd = 1'b0;
    src_valid = 1'b0; src_data = 16'd0; snk_ready = 1'b0;
    dma_ack = 1'b0; dev_out = 16'd0; end_flag = 1'b0; error_flag = 1'b0;
    test_reset();
    test_write(5, -1, 17'h00200, 16'hD000);
    test_read8();
    test_zero_words();
    test_write(6, 3, 17'h00300, 16'hC000);
    test_write(1, -1, 17'h1FFFE, 16'h5A00);
    test_reset_mid_read();
    test_no_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
